// File: rtl/img_lut_loader_pkg.sv
// Shared types for the LUT table loader: FSM states, error codes, depth helper.
package img_lut_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDiscard
    } lut_load_state_t;

    typedef enum logic [1:0] {
        ErrNone    = 2'd0,
        ErrShort   = 2'd1,
        ErrLong    = 2'd2,
        ErrRestart = 2'd3
    } lut_load_err_t;

    // Number of LUT entries addressed by a px_width-bit pixel.
    function automatic int unsigned lut_depth(input int unsigned px_width);
        return 32'd1 << px_width;
    endfunction

endpackage

// File: rtl/img_lut_loader.sv
// Turns an AXI4-Stream table packet (one entry per beat) into sequential LUT
// write strobes, checks the table framing and reports completion or errors.
module img_lut_loader
    import img_lut_loader_pkg::*;
#(
    parameter int unsigned PxWidth    = 10,
    parameter int unsigned TdataWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // table stream (slave)
    input  logic                  table_tvalid_i,
    output logic                  table_tready_o,
    input  logic [TdataWidth-1:0] table_tdata_i,
    input  logic                  table_tuser_i,
    input  logic                  table_tlast_i,
    // LUT control port (master)
    output logic                  lut_wr_o,
    output logic [PxWidth-1:0]    lut_addr_o,
    output logic [PxWidth-1:0]    lut_data_o,
    // status
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    // One extra counter bit so a beat arriving after the last entry is visible.
    localparam int unsigned    CntW    = PxWidth + 1;
    localparam logic [CntW-1:0] Depth   = CntW'(lut_depth(PxWidth));
    localparam logic [CntW-1:0] LastIdx = Depth - CntW'(1);

    lut_load_state_t      state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [PxWidth-1:0]   addr_q, addr_d;
    logic [PxWidth-1:0]   data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    lut_load_err_t        code_q, code_d;

    logic                 beat;
    logic [PxWidth-1:0]   entry;

    // The write port never stalls, so the stream is only held off during reset.
    assign table_tready_o = rst_n_i;
    assign beat           = table_tvalid_i & table_tready_o;
    assign entry          = table_tdata_i[PxWidth-1:0];

    if (TdataWidth > PxWidth) begin : g_pad
        logic unused_tdata_pad;
        assign unused_tdata_pad = ^table_tdata_i[TdataWidth-1:PxWidth];
    end

    // Next-state decode: framing rules applied to each accepted beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = ErrNone;
        if (beat) begin
            if (table_tuser_i) begin
                // A first-entry marker always opens a new table at address 0.
                wr_d   = 1'b1;
                addr_d = '0;
                data_d = entry;
                if (table_tlast_i) begin
                    err_d   = 1'b1;
                    code_d  = ErrShort;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d   = CntW'(1);
                    state_d = StLoad;
                    if (state_q != StIdle) begin
                        err_d  = 1'b1;
                        code_d = ErrRestart;
                    end
                end
            end else begin
                case (state_q)
                    StLoad: begin
                        if (cnt_q == Depth) begin
                            // Table longer than the LUT: drop, never wrap onto addr 0.
                            err_d   = 1'b1;
                            code_d  = ErrLong;
                            cnt_d   = '0;
                            state_d = table_tlast_i ? StIdle : StDiscard;
                        end else begin
                            wr_d   = 1'b1;
                            addr_d = cnt_q[PxWidth-1:0];
                            data_d = entry;
                            if (table_tlast_i) begin
                                cnt_d   = '0;
                                state_d = StIdle;
                                if (cnt_q == LastIdx) begin
                                    done_d = 1'b1;
                                end else begin
                                    err_d  = 1'b1;
                                    code_d = ErrShort;
                                end
                            end else begin
                                cnt_d = cnt_q + CntW'(1);
                            end
                        end
                    end
                    StDiscard: begin
                        if (table_tlast_i) begin
                            state_d = StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
        busy_d = (state_d != StIdle);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ErrNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign lut_wr_o   = wr_q;
    assign lut_addr_o = addr_q;
    assign lut_data_o = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule
